// File: rtl/rst_sequencer.sv
// Releases N_STAGES downstream reset domains one at a time, waiting for each
// stage to acknowledge; request, lock loss or ack timeout drop every stage again.
module rst_sequencer #(
  parameter int N_STAGES    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8,
  parameter int ACK_TIMEOUT = 256,
  localparam int STAGE_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1,
  localparam int MAX_HD     = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY,
  localparam int MAX_CNT    = (MAX_HD > ACK_TIMEOUT) ? MAX_HD : ACK_TIMEOUT,
  localparam int CNT_W      = $clog2(MAX_CNT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_rst,
  input  logic                pll_locked,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic [N_STAGES-1:0] stage_rst_n,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [STAGE_W-1:0]  cur_stage
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_ACK,
    S_DELAY,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DELAY_LAST = CNT_W'((STAGE_DELAY > 0) ? STAGE_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0]   ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [STAGE_W-1:0]  cur_stage_nxt;
  logic [N_STAGES-1:0] stage_rst_n_nxt;
  logic [N_STAGES-1:0] released_next;
  logic                timeout_err_nxt;
  logic                abort;
  logic                ack_cur;
  logic                last_stage;

  assign abort      = req_rst | ~pll_locked;
  assign ack_cur    = stage_ack[cur_stage];
  assign last_stage = (cur_stage == LAST_STAGE);
  assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  // Released bits always form a contiguous run from bit 0, so shifting in a
  // one releases exactly the next stage in order.
  assign released_next = (stage_rst_n << 1) | N_STAGES'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HOLD;
      cnt         <= '0;
      cur_stage   <= '0;
      stage_rst_n <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cur_stage   <= cur_stage_nxt;
      stage_rst_n <= stage_rst_n_nxt;
      busy        <= (state_nxt != S_RUN);
      done        <= (state_nxt == S_RUN);
      timeout_err <= timeout_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_HOLD;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) state_nxt = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (ack_cur) begin
            if (last_stage)           state_nxt = S_RUN;
            else if (STAGE_DELAY > 0) state_nxt = S_DELAY;
          end else if (cnt == ACK_LAST) begin
            state_nxt = S_ERROR;
          end
        end
        S_DELAY: begin
          if (cnt == DELAY_LAST) state_nxt = S_WAIT_ACK;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Counter, stage index and reset outputs; an ack seen in the timeout cycle
  // is taken before the timeout check.
  always_comb begin
    cnt_nxt         = cnt;
    cur_stage_nxt   = cur_stage;
    stage_rst_n_nxt = stage_rst_n;
    timeout_err_nxt = timeout_err & ~req_rst;
    if (abort) begin
      cnt_nxt         = '0;
      cur_stage_nxt   = '0;
      stage_rst_n_nxt = '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            stage_rst_n_nxt = released_next;
            cnt_nxt         = '0;
            cur_stage_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_WAIT_ACK: begin
          if (ack_cur) begin
            cnt_nxt = '0;
            if (!last_stage && STAGE_DELAY == 0) begin
              stage_rst_n_nxt = released_next;
              cur_stage_nxt   = cur_stage + 1'b1;
            end
          end else if (cnt == ACK_LAST) begin
            timeout_err_nxt = 1'b1;
            stage_rst_n_nxt = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_DELAY: begin
          if (cnt == DELAY_LAST) begin
            stage_rst_n_nxt = released_next;
            cur_stage_nxt   = cur_stage + 1'b1;
            cnt_nxt         = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_RUN: begin
          stage_rst_n_nxt = '1;
        end
        default: begin
          stage_rst_n_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: three builds (default, zero-delay, single-stage)
// share rst/req/lock and are scored against a timestamp-based reference model.
module tb_rst_sequencer;

  localparam int N0 = 4, H0 = 16, D0 = 8, T0 = 256;
  localparam int N1 = 3, H1 = 3,  D1 = 0, T1 = 6;
  localparam int N2 = 1, H2 = 2,  D2 = 2, T2 = 4;

  typedef struct packed {
    logic [3:0] srn;
    logic       busy;
    logic       done;
    logic       terr;
    logic [1:0] cur;
  } exp_t;

  typedef struct packed {
    int   edge_no;
    exp_t e;
  } dir_t;

  logic       clk = 1'b0;
  logic       rst, req_rst, pll_locked;
  logic [3:0] ack0, srn0;
  logic [2:0] ack1, srn1;
  logic [0:0] ack2, srn2;
  logic       busy0, busy1, busy2, done0, done1, done2, terr0, terr1, terr2;
  logic [1:0] cur0, cur1;
  logic [0:0] cur2;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  bit mon_on = 1'b1;

  exp_t [2:0] sb_q [$];
  dir_t       dir_q [$];

  // Reference model state: timestamps of the events that define each phase.
  int p_n[3], p_hold[3], p_dly[3], p_to[3];
  int released[3], cur_m[3], hold_start[3], wait_start[3], ack_edge[3];
  bit terr_m[3], in_err[3], running[3], pending[3];
  int rel_edge[3][4];
  int lat[3][4];

  rst_sequencer #(.N_STAGES(N0), .HOLD_CYCLES(H0), .STAGE_DELAY(D0), .ACK_TIMEOUT(T0)) dut0 (
    .clk(clk), .rst(rst), .req_rst(req_rst), .pll_locked(pll_locked), .stage_ack(ack0),
    .stage_rst_n(srn0), .busy(busy0), .done(done0), .timeout_err(terr0), .cur_stage(cur0));
  rst_sequencer #(.N_STAGES(N1), .HOLD_CYCLES(H1), .STAGE_DELAY(D1), .ACK_TIMEOUT(T1)) dut1 (
    .clk(clk), .rst(rst), .req_rst(req_rst), .pll_locked(pll_locked), .stage_ack(ack1),
    .stage_rst_n(srn1), .busy(busy1), .done(done1), .timeout_err(terr1), .cur_stage(cur1));
  rst_sequencer #(.N_STAGES(N2), .HOLD_CYCLES(H2), .STAGE_DELAY(D2), .ACK_TIMEOUT(T2)) dut2 (
    .clk(clk), .rst(rst), .req_rst(req_rst), .pll_locked(pll_locked), .stage_ack(ack2),
    .stage_rst_n(srn2), .busy(busy2), .done(done2), .timeout_err(terr2), .cur_stage(cur2));

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic checkOutput(input string name, input exp_t got, input exp_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s edge=%0d got srn=%b busy=%b done=%b terr=%b cur=%0d required srn=%b busy=%b done=%b terr=%b cur=%0d",
               name, edge_n, got.srn, got.busy, got.done, got.terr, got.cur,
               exp.srn, exp.busy, exp.done, exp.terr, exp.cur);
    end
  endtask

  function automatic exp_t modelOut(input int i);
    exp_t e;
    e.srn  = in_err[i] ? 4'd0 : 4'((1 << released[i]) - 1);
    e.busy = ~running[i];
    e.done = running[i];
    e.terr = terr_m[i];
    e.cur  = 2'(cur_m[i]);
    return e;
  endfunction

  task automatic releaseNext(input int i, input int t);
    released[i]++;
    cur_m[i]++;
    wait_start[i] = t;
    rel_edge[i][cur_m[i]] = t;
  endtask

  task automatic modelStep(input int i, input int t, input bit r, input bit q, input bit lk, input bit a);
    if (r || q || !lk) begin
      released[i] = 0; cur_m[i] = 0; in_err[i] = 0; running[i] = 0; pending[i] = 0;
      hold_start[i] = t;
      if (r || q) terr_m[i] = 0;
    end else if (in_err[i] || running[i]) begin
      // parked until the next abort
    end else if (released[i] == 0) begin
      if (t - hold_start[i] == p_hold[i]) begin
        released[i] = 1; cur_m[i] = 0; wait_start[i] = t; rel_edge[i][0] = t;
      end
    end else if (pending[i]) begin
      if (t - ack_edge[i] == p_dly[i]) begin
        pending[i] = 0;
        releaseNext(i, t);
      end
    end else if (a) begin
      if (cur_m[i] == p_n[i] - 1) running[i] = 1;
      else if (p_dly[i] == 0)     releaseNext(i, t);
      else begin pending[i] = 1; ack_edge[i] = t; end
    end else if (t - wait_start[i] == p_to[i]) begin
      in_err[i] = 1; terr_m[i] = 1;
    end
  endtask

  // A stage acks lat cycles after its release; lat==0 means it never acks.
  function automatic bit policyAck(input int i, input int t);
    int c = cur_m[i];
    if (released[i] <= c || lat[i][c] == 0) return 1'b0;
    return (t - rel_edge[i][c]) >= lat[i][c];
  endfunction

  task automatic applyStimulus(input bit r, input bit q, input bit lk);
    int t;
    bit a [3];
    logic [3:0] v0;
    logic [2:0] v1;
    exp_t [2:0] ev;
    t = edge_n + 1;
    for (int i = 0; i < 3; i++) a[i] = policyAck(i, t);
    v0 = 4'($urandom); v0[cur_m[0]] = a[0];
    v1 = 3'($urandom); v1[cur_m[1]] = a[1];
    ack0 = v0; ack1 = v1; ack2 = a[2];
    rst = r; req_rst = q; pll_locked = lk;
    for (int i = 0; i < 3; i++) begin
      modelStep(i, t, r, q, lk, a[i]);
      ev[i] = modelOut(i);
    end
    sb_q.push_back(ev);
    @(negedge clk);
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic pushDir(input int e, input logic [3:0] s, input logic b, input logic d,
                         input logic te, input int c);
    dir_t x;
    x.edge_no = e; x.e.srn = s; x.e.busy = b; x.e.done = d; x.e.terr = te; x.e.cur = 2'(c);
    dir_q.push_back(x);
  endtask

  task automatic randomLats();
    for (int s = 0; s < 4; s++) begin
      int pick = $urandom_range(0, 19);
      lat[0][s] = (pick == 0) ? 0 : (pick == 1) ? $urandom_range(255, 257) : $urandom_range(1, 12);
      lat[1][s] = $urandom_range(0, 7);
      lat[2][s] = $urandom_range(0, 5);
    end
  endtask

  task automatic setLat0(input int a, input int b, input int c, input int d);
    lat[0][0] = a; lat[0][1] = b; lat[0][2] = c; lat[0][3] = d;
  endtask

  exp_t [2:0] mon_ev;
  dir_t       mon_d;
  exp_t       got0, got1, got2;

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      got0 = {srn0, busy0, done0, terr0, cur0};
      got1 = {1'b0, srn1, busy1, done1, terr1, cur1};
      got2 = {3'b000, srn2, busy2, done2, terr2, 1'b0, cur2};
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL sb_underflow edge=%0d got queue size 0 required >0", edge_n);
      end else begin
        mon_ev = sb_q.pop_front();
        checkOutput("dut0", got0, mon_ev[0]);
        checkOutput("dut1_delay0", got1, mon_ev[1]);
        checkOutput("dut2_single", got2, mon_ev[2]);
      end
      if (dir_q.size() > 0 && dir_q[0].edge_no <= edge_n) begin
        mon_d = dir_q.pop_front();
        if (mon_d.edge_no == edge_n) checkOutput("directed", got0, mon_d.e);
        else begin
          total++; bad++;
          $display("[TB] FAIL directed_missed got edge=%0d required edge=%0d", edge_n, mon_d.edge_no);
        end
      end
    end
  end

  initial begin
    int r, p, q;
    p_n = '{N0, N1, N2}; p_hold = '{H0, H1, H2}; p_dly = '{D0, D1, D2}; p_to = '{T0, T1, T2};
    for (int i = 0; i < 3; i++) begin
      released[i] = 0; cur_m[i] = 0; hold_start[i] = 0; wait_start[i] = 0; ack_edge[i] = 0;
      terr_m[i] = 0; in_err[i] = 0; running[i] = 0; pending[i] = 0;
      for (int s = 0; s < 4; s++) rel_edge[i][s] = 0;
    end
    randomLats();

    $display("[TB] nominal sequence");
    setLat0(2, 2, 2, 2);
    r = edge_n + 1;
    pushDir(r + 15, 4'b0000, 1, 0, 0, 0);
    pushDir(r + 16, 4'b0001, 1, 0, 0, 0);
    pushDir(r + 25, 4'b0001, 1, 0, 0, 0);
    pushDir(r + 26, 4'b0011, 1, 0, 0, 1);
    pushDir(r + 36, 4'b0111, 1, 0, 0, 2);
    pushDir(r + 46, 4'b1111, 1, 0, 0, 3);
    pushDir(r + 47, 4'b1111, 1, 0, 0, 3);
    pushDir(r + 48, 4'b1111, 0, 1, 0, 3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(59);

    $display("[TB] hold restart on lock loss");
    randomLats(); setLat0(2, 2, 2, 2);
    r = edge_n + 1;
    pushDir(r + 16, 4'b0000, 1, 0, 0, 0);
    pushDir(r + 27, 4'b0000, 1, 0, 0, 0);
    pushDir(r + 28, 4'b0001, 1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(9);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    runCycles(40);

    $display("[TB] ack timeout on stage 2");
    randomLats(); setLat0(2, 2, 0, 2);
    r = edge_n + 1;
    pushDir(r + 291, 4'b0111, 1, 0, 0, 2);
    pushDir(r + 292, 4'b0000, 1, 0, 1, 2);
    pushDir(r + 300, 4'b0000, 1, 0, 1, 2);
    pushDir(r + 306, 4'b0000, 1, 0, 1, 0);
    pushDir(r + 322, 4'b0001, 1, 0, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(305);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runCycles(24);
    setLat0(1, 1, 1, 1);
    p = edge_n + 1;
    pushDir(p,      4'b0000, 1, 0, 0, 0);
    pushDir(p + 42, 4'b0111, 1, 0, 0, 2);
    pushDir(p + 43, 4'b1111, 1, 0, 0, 3);
    pushDir(p + 44, 4'b1111, 0, 1, 0, 3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    runCycles(59);

    $display("[TB] ack in the timeout cycle");
    randomLats(); setLat0(2, 256, 2, 2);
    r = edge_n + 1;
    pushDir(r + 281, 4'b0011, 1, 0, 0, 1);
    pushDir(r + 282, 4'b0011, 1, 0, 0, 1);
    pushDir(r + 290, 4'b0111, 1, 0, 0, 2);
    pushDir(r + 302, 4'b1111, 0, 1, 0, 3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(310);

    $display("[TB] abort from run");
    setLat0(2, 2, 2, 2);
    q = edge_n + 1;
    pushDir(q,      4'b0000, 1, 0, 0, 0);
    pushDir(q + 15, 4'b0000, 1, 0, 0, 0);
    pushDir(q + 16, 4'b0001, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    runCycles(59);

    $display("[TB] randomized episodes");
    for (int ep = 0; ep < 40; ep++) begin
      randomLats();
      if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, 1'b0, 1'b1);
      for (int c = 0; c < 100; c++) begin
        applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 149) == 0,
                      $urandom_range(0, 199) != 0);
      end
    end

    mon_on = 1'b0;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_leftover got %0d entries required 0", sb_q.size());
    end
    total++;
    if (dir_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL directed_leftover got %0d entries required 0", dir_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
